// File: rtl/cacheline_burst_adaptor.sv
// Cache line (256b) to 4-beat 64b memory burst responder.
// One line transaction in flight; read wins over write in IDLE.
module cacheline_burst_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BEAT_WIDTH  = 64,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           line_address_i,
  input  logic                  line_read_i,
  input  logic                  line_write_i,
  input  logic [LINE_WIDTH-1:0] line_wdata_i,
  output logic [LINE_WIDTH-1:0] line_rdata_o,
  output logic                  line_resp_o,
  output logic [31:0]           burst_address_o,
  output logic                  burst_read_o,
  output logic                  burst_write_o,
  output logic [BEAT_WIDTH-1:0] burst_wdata_o,
  input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
  input  logic                  burst_resp_i
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_BURST,
    WR_BURST,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [31:0]             addr_q, addr_d;
  logic [LINE_WIDTH-1:0]   wline_q, wline_d;
  logic [LINE_WIDTH-1:0]   rline_q, rline_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    resp_q, resp_d;
  logic [31:0]             line_base;

  assign line_base = {line_address_i[31:OFFSET_BITS],
                      OFFSET_BITS'(0)};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    resp_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (line_read_i) begin
          addr_d  = line_base;
          cnt_d   = '0;
          rd_d    = 1'b1;
          state_d = RD_BURST;
        end else if (line_write_i) begin
          addr_d  = line_base;
          wline_d = line_wdata_i;
          cnt_d   = '0;
          wr_d    = 1'b1;
          state_d = WR_BURST;
        end
      end
      RD_BURST: begin
        if (burst_resp_i) begin
          rline_d[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata_i;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      WR_BURST: begin
        if (burst_resp_i) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            wr_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
    end
  end

  assign line_rdata_o    = rline_q;
  assign line_resp_o     = resp_q;
  assign burst_address_o = addr_q;
  assign burst_read_o    = rd_q;
  assign burst_write_o   = wr_q;
  assign burst_wdata_o   = wline_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];

endmodule

// File: doc/cacheline_burst_adaptor.md
Name: cacheline_burst_adaptor

Overview:
Memory-side responder for the cache's 256-bit line interface (the pmem_* port of the data/instruction caches). It accepts one whole-line read or write request from a cache and turns it into a 4-beat, 64-bit burst on the physical memory bus. For reads it assembles the incoming beats into a line and returns it; for writes it serialises the latched line. One line transaction is in flight at a time.

Parameters:
LINE_WIDTH, 256, cache line width in bits; must be a multiple of BEAT_WIDTH.
BEAT_WIDTH, 64, memory bus beat width in bits.
OFFSET_BITS, 5, line-offset bits forced to zero on address_o (log2 of LINE_WIDTH/8).
BEATS, LINE_WIDTH/BEAT_WIDTH (4), derived; beats per burst; counter width is clog2(BEATS).

Ports:
clk  input  1  sole clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
line_address_i  input  32  line address from the cache (pmem_address).
line_read_i  input  1  cache line-read request; held until line_resp_o.
line_write_i  input  1  cache line-write request; held until line_resp_o.
line_wdata_i  input  LINE_WIDTH  line to write (pmem_wdata).
line_rdata_o  output  LINE_WIDTH  assembled read line (pmem_rdata).
line_resp_o  output  1  one-cycle completion pulse (pmem_resp).
burst_address_o  output  32  latched line address, low OFFSET_BITS forced to 0.
burst_read_o  output  1  memory read burst request.
burst_write_o  output  1  memory write burst request.
burst_wdata_o  output  BEAT_WIDTH  current write beat.
burst_rdata_i  input  BEAT_WIDTH  current read beat.
burst_resp_i  input  1  memory beat strobe; one beat is transferred per high cycle.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, beat counter 0, line_resp_o 0, burst_read_o 0, burst_write_o 0, burst_address_o 0, burst_wdata_o 0, line_rdata_o 0, and the internal write-line buffer 0.
- States: IDLE, RD_BURST, WR_BURST, DONE.
- IDLE:
  - If line_read_i is high, latch the address, clear the counter and go to RD_BURST.
  - Else if line_write_i is high, latch the address and line_wdata_i, clear the counter and go to WR_BURST.
  - If both are high (illegal), the read wins.
  - burst_resp_i is ignored in IDLE.
- Latency to the memory bus: a request seen at edge N makes burst_read_o/burst_write_o high from cycle N+1. These outputs are registered.
- RD_BURST:
  - burst_read_o is high.
  - On each edge with burst_resp_i high, burst_rdata_i is written into line_rdata_o bits [BEAT_WIDTH*cnt +: BEAT_WIDTH] and cnt increments. Beat 0 is the least-significant 64 bits.
  - Cycles with burst_resp_i low are wait states: no state change.
  - On the beat where cnt == BEATS-1, go to DONE and drop burst_read_o at that same edge.
- WR_BURST:
  - burst_write_o is high.
  - burst_wdata_o always equals latched_line[BEAT_WIDTH*cnt +: BEAT_WIDTH].
  - Each burst_resp_i high cycle advances cnt.
  - On the final beat, go to DONE and drop burst_write_o.
- DONE:
  - line_resp_o is high for exactly this one cycle, then the block returns to IDLE.
  - A request still asserted during DONE is not sampled. A new request is sampled only in IDLE, i.e. the earliest next start is 2 cycles after the final beat.
- line_rdata_o holds its value after DONE until the next read burst starts overwriting beats. It is undefined during a write or a partial read.
- burst_address_o holds its value across the whole burst even if line_address_i changes. Its low OFFSET_BITS are always 0.
- Protocol violations:
  - Request deasserted mid-burst: the burst still completes and line_resp_o still pulses.
  - burst_resp_i while not in a burst state: ignored.
- Reset mid-burst: immediate return to IDLE with all outputs at their reset values. The partial line is discarded and no line_resp_o is issued.

Test Plan:
1. Read at 0x0000_1234, burst_resp_i high for 4 consecutive cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> burst_address_o = 0x0000_1220; line_rdata_o = {0x44..,0x33..,0x22..,0x11..}; line_resp_o pulses once, 1 cycle after beat 4; burst_read_o low in that cycle.
2. Write of line {D3,D2,D1,D0} to 0x8000_0040, burst_resp_i with a 2-cycle gap between beats 1 and 2 -> burst_wdata_o = D0,D1,D1(held),D1(held),D2,D3 on the respective cycles; exactly 4 beats consumed; one line_resp_o.
3. Write immediately followed by a read (cache drops write_i and raises read_i in the DONE cycle) -> read not started in DONE; burst_read_o rises 2 cycles after the final write beat; address re-latched.
4. rst driven low asynchronously after beat 2 of a read -> outputs go to 0 without waiting for a clock edge; no line_resp_o; a subsequent read completes normally with 4 fresh beats.
5. burst_resp_i pulsed while IDLE, and line_address_i changed mid-burst -> no state change in IDLE; burst_address_o stays at the latched value for the whole burst.
6. line_read_i and line_write_i both high in IDLE -> a read burst is performed (burst_write_o stays 0).
